// File: rtl/snitch_hive_acc_credit.sv
// Per-core credit stage between a core's accelerator offload port and the hive arbiter.
// Optional credit-stall statistics counter: define SNITCH_HIVE_ACC_CREDIT_STATS_EN.
module snitch_hive_acc_credit #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   core_qvalid_i,
  output logic                   core_qready_o,
  input  logic [31:0]            core_qaddr_i,
  input  logic [IdWidth-1:0]     core_qid_i,
  input  logic [31:0]            core_qop_i,
  input  logic [3*DataWidth-1:0] core_qarg_i,
  output logic                   hive_qvalid_o,
  input  logic                   hive_qready_i,
  output logic [31:0]            hive_qaddr_o,
  output logic [IdWidth-1:0]     hive_qid_o,
  output logic [31:0]            hive_qop_o,
  output logic [3*DataWidth-1:0] hive_qarg_o,
  input  logic                   hive_pvalid_i,
  output logic                   hive_pready_o,
  input  logic [IdWidth-1:0]     hive_pid_i,
  input  logic                   hive_perror_i,
  input  logic [DataWidth-1:0]   hive_pdata_i,
  output logic                   core_pvalid_o,
  input  logic                   core_pready_i,
  output logic [IdWidth-1:0]     core_pid_o,
  output logic                   core_perror_o,
  output logic [DataWidth-1:0]   core_pdata_o,
  output logic [CntWidth-1:0]    credits_o,
  output logic [31:0]            stall_cnt_o
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0] Max = CntWidth'(MaxOutstanding);

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic                 error;
    logic [DataWidth-1:0] data;
  } rsp_t;

  rsp_t                mem [MaxOutstanding];
  rsp_t                head;
  logic [PtrWidth-1:0] wptr, rptr;
  logic [CntWidth-1:0] cnt, fill;
  logic                at_limit, full, empty, req, push, pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign at_limit = (cnt == Max);
  assign full     = (fill == Max);
  assign empty    = (fill == '0);

  assign hive_qvalid_o = core_qvalid_i & ~at_limit;
  assign core_qready_o = hive_qready_i & ~at_limit;
  assign hive_qaddr_o  = core_qaddr_i;
  assign hive_qid_o    = core_qid_i;
  assign hive_qop_o    = core_qop_i;
  assign hive_qarg_o   = core_qarg_i;

  assign req  = hive_qvalid_o & hive_qready_i;
  assign push = hive_pvalid_i & ~full;
  assign pop  = ~empty & core_pready_i;

  // Head entry comes straight from storage, so a push only shows up after the edge.
  assign head          = mem[rptr];
  assign hive_pready_o = ~full;
  assign core_pvalid_o = ~empty;
  assign core_pid_o    = head.id;
  assign core_perror_o = head.error;
  assign core_pdata_o  = head.data;
  assign credits_o     = cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt  <= '0;
      fill <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      // Credit returns only when the core consumes the response.
      if (req && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !req) cnt <= cnt - 1'b1;
      if (push && !pop)      fill <= fill + 1'b1;
      else if (pop && !push) fill <= fill - 1'b1;
      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= '{id: hive_pid_i, error: hive_perror_i, data: hive_pdata_i};
  end

`ifdef SNITCH_HIVE_ACC_CREDIT_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (core_qvalid_i && hive_qready_i && at_limit && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = 32'h0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(pop && cnt == '0)) else $error("credit underflow on response pop");
      assert (!(hive_pvalid_i && full)) else $error("response offered while buffer full");
    end
  end

endmodule

// File: tb/tb_snitch_hive_acc_credit.sv
// Bench for snitch_hive_acc_credit: queue-based reference model, directed scenarios, random traffic.
module tb_snitch_hive_acc_credit;
  localparam int DW  = 32;
  localparam int IW  = 5;
  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);
`ifdef SNITCH_HIVE_ACC_CREDIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic core_qvalid, core_qready, hive_qvalid, hive_qready;
  logic [31:0] core_qaddr, core_qop, hive_qaddr, hive_qop;
  logic [IW-1:0] core_qid, hive_qid, hive_pid, core_pid;
  logic [3*DW-1:0] core_qarg, hive_qarg;
  logic hive_pvalid, hive_pready, hive_perror, core_pvalid, core_pready, core_perror;
  logic [DW-1:0] hive_pdata, core_pdata;
  logic [CW-1:0] credits;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  snitch_hive_acc_credit #(.DataWidth(DW), .IdWidth(IW), .MaxOutstanding(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_qvalid_i(core_qvalid), .core_qready_o(core_qready), .core_qaddr_i(core_qaddr),
    .core_qid_i(core_qid), .core_qop_i(core_qop), .core_qarg_i(core_qarg),
    .hive_qvalid_o(hive_qvalid), .hive_qready_i(hive_qready), .hive_qaddr_o(hive_qaddr),
    .hive_qid_o(hive_qid), .hive_qop_o(hive_qop), .hive_qarg_o(hive_qarg),
    .hive_pvalid_i(hive_pvalid), .hive_pready_o(hive_pready), .hive_pid_i(hive_pid),
    .hive_perror_i(hive_perror), .hive_pdata_i(hive_pdata),
    .core_pvalid_o(core_pvalid), .core_pready_i(core_pready), .core_pid_o(core_pid),
    .core_perror_o(core_perror), .core_pdata_o(core_pdata),
    .credits_o(credits), .stall_cnt_o(stall_cnt)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  int total = 0, bad = 0;
  rsp_t mfifo[$];
  logic [IW-1:0] pend[$];
  int mcnt = 0;
  longint mstall = 0;
  bit m_req, m_pop, m_push;
  logic [DW-1:0] d [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: credit count, response queue, stall count.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mfifo.delete();
      pend.delete();
      mcnt   = 0;
      mstall = 0;
    end else begin
      m_req  = core_qvalid && hive_qready && (mcnt != MAX);
      m_pop  = (mfifo.size() != 0) && core_pready;
      m_push = hive_pvalid && (mfifo.size() != MAX);
      if (core_qvalid && hive_qready && mcnt == MAX && mstall < 64'hFFFF_FFFF) mstall++;
      if (m_req) pend.push_back(core_qid);
      if (m_push) begin
        mfifo.push_back('{id: hive_pid, err: hive_perror, data: hive_pdata});
        if (pend.size() != 0) void'(pend.pop_front());
      end
      if (m_pop) void'(mfifo.pop_front());
      mcnt = mcnt + int'(m_req) - int'(m_pop);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("hive_qvalid", hive_qvalid, core_qvalid && (mcnt != MAX));
      chk("core_qready", core_qready, hive_qready && (mcnt != MAX));
      chk("qpayload", {hive_qaddr, hive_qid, hive_qop, hive_qarg} == {core_qaddr, core_qid, core_qop, core_qarg}, 1);
      chk("hive_pready", hive_pready, mfifo.size() != MAX);
      chk("core_pvalid", core_pvalid, mfifo.size() != 0);
      if (mfifo.size() != 0) chk("core_prsp", {core_pid, core_perror, core_pdata}, mfifo[0]);
      chk("credits", credits, mcnt);
      chk("stall_cnt", stall_cnt, STATS ? mstall : 0);
    end
  end

  initial begin
    core_qvalid = 0; core_qaddr = 32'h1000; core_qid = '0; core_qop = 32'h0000_000B; core_qarg = '0;
    hive_qready = 0; hive_pvalid = 0; hive_pid = '0; hive_perror = 0; hive_pdata = '0; core_pready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst_core_pvalid", core_pvalid, 0);
    chk("rst_hive_pready", hive_pready, 1);
    chk("rst_credits", credits, 0);
    chk("rst_stall", stall_cnt, 0);

    // Single op, id 3
    core_qvalid = 1; core_qid = 3; hive_qready = 1; core_qarg = {32'hC, 32'hB, 32'hA};
    #1 chk("single_hive_qvalid", hive_qvalid, 1);
    chk("single_core_qready", core_qready, 1);
    step();
    core_qvalid = 0;
    #1 chk("single_credits1", credits, 1);
    hive_pvalid = 1; hive_pid = 3; hive_pdata = 32'hDEAD_BEEF; hive_perror = 0;
    #1 chk("no_fallthrough", core_pvalid, 0);
    step();
    hive_pvalid = 0;
    #1 chk("single_pvalid", core_pvalid, 1);
    chk("single_pid", core_pid, 3);
    chk("single_pdata", core_pdata, 32'hDEAD_BEEF);
    core_pready = 1;
    step();
    core_pready = 0;
    #1 chk("single_credits0", credits, 0);

    // Credit limit: five back-to-back requests
    core_qvalid = 1;
    for (int i = 0; i < 4; i++) begin
      core_qid = IW'(i);
      step();
    end
    core_qid = 4;
    #1 chk("limit_credits", credits, 4);
    chk("limit_core_qready", core_qready, 0);
    chk("limit_hive_qvalid", hive_qvalid, 0);
    step(); step(); step();
    #1 chk("limit_stall3", stall_cnt, STATS ? 3 : 0);

    // Slow core: four responses into a stalled consumer
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      hive_pvalid = 1; hive_pid = IW'(i); hive_pdata = d[i]; hive_perror = (i == 2);
      #1 chk("slow_hive_pready", hive_pready, 1);
      step();
    end
    hive_pvalid = 0; hive_perror = 0;
    #1 chk("slow_full", hive_pready, 0);
    chk("slow_head", core_pid, 0);

    // Pop at the limit: request stays blocked this cycle, accepted the next
    core_pready = 1;
    #1 chk("pop_limit_qready", core_qready, 0);
    chk("pop_limit_data", core_pdata, d[0]);
    step();
    core_pready = 0;
    #1 chk("after_pop_qready", core_qready, 1);
    chk("after_pop_credits", credits, 3);
    step();
    core_qvalid = 0;
    #1 chk("reaccept_credits", credits, 4);

    // Drain in order, including the error response
    core_pready = 1;
    for (int i = 1; i < 4; i++) begin
      #1 chk("drain_pid", core_pid, i);
      chk("drain_pdata", core_pdata, d[i]);
      chk("drain_perror", core_perror, i == 2);
      step();
    end
    core_pready = 0;
    #1 chk("drain_hive_pready", hive_pready, 1);
    chk("drain_credits", credits, 1);

    // Reset with two outstanding and one buffered
    core_qvalid = 1; core_qid = 5;
    step();
    core_qid = 6;
    step();
    core_qvalid = 0; hive_pvalid = 1; hive_pid = 4; hive_pdata = 32'h1234_5678;
    step();
    hive_pvalid = 0;
    #1 chk("prerst_credits", credits, 3);
    chk("prerst_pvalid", core_pvalid, 1);
    rst_n = 0;
    #1 chk("midrst_pvalid", core_pvalid, 0);
    chk("midrst_credits", credits, 0);
    chk("midrst_hive_pready", hive_pready, 1);
    step();
    rst_n = 1; core_qvalid = 1; core_qid = 7;
    #1 chk("postrst_qready", core_qready, 1);
    chk("postrst_hive_qvalid", hive_qvalid, 1);
    step();
    core_qvalid = 0;
    #1 chk("postrst_credits", credits, 1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      core_qvalid = ($urandom % 4) != 0;
      core_qid    = IW'($urandom);
      core_qaddr  = $urandom;
      core_qop    = $urandom;
      core_qarg   = {$urandom, $urandom, $urandom};
      hive_qready = ($urandom % 3) != 0;
      core_pready = ($urandom % 3) == 0;
      hive_pvalid = (pend.size() != 0) && (mfifo.size() != MAX) && ($urandom % 2 == 0);
      hive_pid    = (pend.size() != 0) ? pend[0] : IW'($urandom);
      hive_perror = ($urandom % 8) == 0;
      hive_pdata  = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
